// File: rtl/mouse_cond.sv
// mouse_cond: conditions PS/2 mouse controller outputs for the game logic.
// Synchronises the position and button inputs, passes a position through only
// when it has held for two samples, clamps it to the screen bounds, debounces
// the buttons, and raises a valid/ready shot event carrying the cursor position
// captured at each left click.
// Optional build macro MOUSE_COND_SHOT_CNT_EN adds the saturating shot_cnt output.
module mouse_cond #(
   parameter int XW              = 12,
   parameter int YW              = 12,
   parameter int SYNC_STAGES     = 2,
   parameter int X_MAX           = 1023,
   parameter int Y_MAX           = 767,
   parameter int DEBOUNCE_CYCLES = 65000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [XW-1:0] xpos_in,
   input  logic [YW-1:0] ypos_in,
   input  logic          left_in,
   input  logic          right_in,
   input  logic          ovr_clr,
   input  logic          shot_ready,
   output logic [XW-1:0] xpos_out,
   output logic [YW-1:0] ypos_out,
   output logic          left_out,
   output logic          right_out,
   output logic          left_press,
   output logic          shot_valid,
   output logic [XW-1:0] shot_x,
   output logic [YW-1:0] shot_y,
   output logic          shot_ovr
`ifdef MOUSE_COND_SHOT_CNT_EN
   ,
   output logic [15:0]   shot_cnt
`endif
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, PENDING} state_t;

   logic [XW-1:0]    x_sync [SYNC_STAGES];
   logic [YW-1:0]    y_sync [SYNC_STAGES];
   logic [1:0]       btn_sync [SYNC_STAGES];
   logic [XW-1:0]    x_prev;
   logic [YW-1:0]    y_prev;
   logic [XW-1:0]    x_last;
   logic [YW-1:0]    y_last;
   logic [1:0]       btn_last;
   logic [1:0]       btn_deb;
   logic [CNT_W-1:0] deb_cnt [2];
   state_t           state;

   // Unsigned clamp of the x axis to the visible screen width.
   function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
      if (v > XW'(X_MAX))
         return XW'(X_MAX);
      return v;
   endfunction

   // Unsigned clamp of the y axis to the visible screen height.
   function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
      if (v > YW'(Y_MAX))
         return YW'(Y_MAX);
      return v;
   endfunction

   assign x_last    = x_sync[SYNC_STAGES-1];
   assign y_last    = y_sync[SYNC_STAGES-1];
   assign btn_last  = btn_sync[SYNC_STAGES-1];
   assign left_out  = btn_deb[0];
   assign right_out = btn_deb[1];

   // Synchroniser chains for every input bit; bit 0 of the button chain is left.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            x_sync[i]   <= '0;
            y_sync[i]   <= '0;
            btn_sync[i] <= '0;
         end
      end else begin
         x_sync[0]   <= xpos_in;
         y_sync[0]   <= ypos_in;
         btn_sync[0] <= {right_in, left_in};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            x_sync[i]   <= x_sync[i-1];
            y_sync[i]   <= y_sync[i-1];
            btn_sync[i] <= btn_sync[i-1];
         end
      end
   end

   // Stability filter: an axis only updates when two consecutive synced samples agree,
   // so a bus caught mid-transition in the synchroniser never reaches the output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_prev   <= '0;
         y_prev   <= '0;
         xpos_out <= '0;
         ypos_out <= '0;
      end else begin
         x_prev <= x_last;
         y_prev <= y_last;
         if (x_last == x_prev)
            xpos_out <= clamp_x(x_last);
         if (y_last == y_prev)
            ypos_out <= clamp_y(y_last);
      end
   end

   // Debounce both buttons; a level must disagree for DEBOUNCE_CYCLES consecutive
   // cycles before it is accepted. left_press fires on the same edge left_out rises.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_deb    <= '0;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
         left_press <= 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (btn_last[b] == btn_deb[b]) begin
               deb_cnt[b] <= '0;
            end else if (deb_cnt[b] == CNT_LAST) begin
               btn_deb[b] <= ~btn_deb[b];
               deb_cnt[b] <= '0;
            end else begin
               deb_cnt[b] <= deb_cnt[b] + CNT_W'(1);
            end
         end
         left_press <= (btn_last[0] != btn_deb[0]) && (deb_cnt[0] == CNT_LAST) && !btn_deb[0];
      end
   end

   // Shot FSM: captures the cursor on a click and holds it until the consumer accepts;
   // a click arriving while a shot is still unaccepted is dropped and flagged sticky.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         shot_valid <= 1'b0;
         shot_x     <= '0;
         shot_y     <= '0;
         shot_ovr   <= 1'b0;
      end else begin
         // A lost press in this cycle takes priority over the clear request.
         if ((state == PENDING) && left_press && !shot_ready)
            shot_ovr <= 1'b1;
         else if (ovr_clr)
            shot_ovr <= 1'b0;

         case (state)
            IDLE: begin
               if (left_press) begin
                  shot_x     <= xpos_out;
                  shot_y     <= ypos_out;
                  shot_valid <= 1'b1;
                  state      <= PENDING;
               end
            end
            PENDING: begin
               if (shot_ready && left_press) begin
                  shot_x <= xpos_out;
                  shot_y <= ypos_out;
               end else if (shot_ready) begin
                  shot_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               shot_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

`ifdef MOUSE_COND_SHOT_CNT_EN
   logic [15:0] shot_cnt_q;
   assign shot_cnt = shot_cnt_q;

   // Count accepted shot handshakes, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n)
         shot_cnt_q <= '0;
      else if (shot_valid && shot_ready && (shot_cnt_q != 16'hFFFF))
         shot_cnt_q <= shot_cnt_q + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mouse_cond.sv
// tb_mouse_cond: directed bench for mouse_cond with SYNC_STAGES=2 and
// DEBOUNCE_CYCLES=4; every expected value below is worked out by hand.
module tb_mouse_cond;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] xpos_in, ypos_in;
   logic        left_in, right_in, ovr_clr, shot_ready;
   logic [11:0] xpos_out, ypos_out, shot_x, shot_y;
   logic        left_out, right_out, left_press, shot_valid, shot_ovr;
`ifdef MOUSE_COND_SHOT_CNT_EN
   logic [15:0] shot_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mouse_cond #(
      .XW(12), .YW(12), .SYNC_STAGES(2), .X_MAX(1023), .Y_MAX(767), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .xpos_in(xpos_in), .ypos_in(ypos_in),
      .left_in(left_in), .right_in(right_in),
      .ovr_clr(ovr_clr), .shot_ready(shot_ready),
      .xpos_out(xpos_out), .ypos_out(ypos_out),
      .left_out(left_out), .right_out(right_out),
      .left_press(left_press), .shot_valid(shot_valid),
      .shot_x(shot_x), .shot_y(shot_y), .shot_ovr(shot_ovr)
`ifdef MOUSE_COND_SHOT_CNT_EN
      , .shot_cnt(shot_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Release the button long enough to debounce low, then press until left_press is seen.
   // Returns just after the edge on which left_press reads 1.
   task automatic press();
      bit seen;
      seen    = 0;
      left_in = 1'b0;
      repeat (8) tick();
      left_in = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (left_press) seen = 1;
      end
      chk("press_seen", 32'(seen), 32'd1);
   endtask

   task automatic set_pos(input logic [11:0] x, input logic [11:0] y);
      xpos_in = x;
      ypos_in = y;
      repeat (6) tick();
   endtask

   initial begin
      int presses;
      rst_n = 1'b0; xpos_in = 12'd500; ypos_in = 12'd0;
      left_in = 1'b1; right_in = 1'b0; ovr_clr = 1'b0; shot_ready = 1'b0;

      // Reset: outputs stay zero while rst_n is low.
      repeat (4) tick();
      chk("rst_xpos", 32'(xpos_out), 0);
      chk("rst_left", 32'(left_out), 0);
      chk("rst_press", 32'(left_press), 0);
      chk("rst_valid", 32'(shot_valid), 0);
      chk("rst_shotx", 32'(shot_x), 0);
      chk("rst_ovr", 32'(shot_ovr), 0);
      rst_n = 1'b1; left_in = 1'b0;
      // Edge 1 is the first post-reset sample; 500 appears on edge 4.
      repeat (3) tick();
      chk("lat_edge3", 32'(xpos_out), 0);
      tick();
      chk("lat_edge4", 32'(xpos_out), 500);

      // Clamp boundaries.
      set_pos(12'd1500, 12'd767);
      chk("clamp_x_over", 32'(xpos_out), 1023);
      chk("clamp_y_equal", 32'(ypos_out), 767);
      set_pos(12'd1023, 12'd768);
      chk("clamp_x_equal", 32'(xpos_out), 1023);
      chk("clamp_y_over", 32'(ypos_out), 767);

      // Filter: an input toggling every cycle never passes.
      set_pos(12'd10, 12'd5);
      chk("filt_stable", 32'(xpos_out), 10);
      for (int i = 0; i < 12; i++) begin
         xpos_in = (i % 2 == 0) ? 12'd20 : 12'd10;
         tick();
      end
      chk("filt_toggle", 32'(xpos_out), 10);

      // Debounce: a 3-cycle glitch is rejected.
      set_pos(12'd300, 12'd200);
      left_in = 1'b1;
      repeat (3) tick();
      left_in = 1'b0;
      presses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (left_press || left_out) presses++;
      end
      chk("glitch_reject", 32'(presses), 0);

      // Debounce: a 10-cycle hold is accepted with exactly one press pulse.
      left_in = 1'b1;
      presses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (left_press) presses++;
      end
      chk("deb_left_out", 32'(left_out), 1);
      chk("deb_one_press", 32'(presses), 1);

      // Shot held while the consumer stalls.
      repeat (5) tick();
      chk("shot_valid", 32'(shot_valid), 1);
      chk("shot_x", 32'(shot_x), 300);
      chk("shot_y", 32'(shot_y), 200);
      shot_ready = 1'b1; tick(); shot_ready = 1'b0;
      chk("shot_accept", 32'(shot_valid), 0);
`ifdef MOUSE_COND_SHOT_CNT_EN
      chk("cnt_1", 32'(shot_cnt), 1);
`endif

      // Overrun: new shot at (300,200), then presses while it is unaccepted.
      press(); tick();
      chk("ovr_pend_valid", 32'(shot_valid), 1);
      set_pos(12'd600, 12'd500);
      press(); tick();
      chk("ovr_set", 32'(shot_ovr), 1);
      chk("ovr_x_held", 32'(shot_x), 300);
      chk("ovr_y_held", 32'(shot_y), 200);
      press(); ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("ovr_set_wins", 32'(shot_ovr), 1);
      chk("ovr_x_held2", 32'(shot_x), 300);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("ovr_clear", 32'(shot_ovr), 0);
      shot_ready = 1'b1; tick(); shot_ready = 1'b0;
      chk("ovr_accept", 32'(shot_valid), 0);
`ifdef MOUSE_COND_SHOT_CNT_EN
      chk("cnt_2", 32'(shot_cnt), 2);
`endif

      // Press coinciding with acceptance relatches and stays pending.
      press(); tick();
      chk("rel_pend", 32'(shot_valid), 1);
      chk("rel_first_x", 32'(shot_x), 600);
      set_pos(12'd700, 12'd50);
      press(); shot_ready = 1'b1; tick(); shot_ready = 1'b0;
      chk("rel_valid", 32'(shot_valid), 1);
      chk("rel_x", 32'(shot_x), 700);
      chk("rel_y", 32'(shot_y), 50);
      chk("rel_no_ovr", 32'(shot_ovr), 0);
      shot_ready = 1'b1; tick(); shot_ready = 1'b0;
      chk("rel_accept", 32'(shot_valid), 0);
`ifdef MOUSE_COND_SHOT_CNT_EN
      // Handshakes so far: one, one, the relatch cycle, and the final accept.
      chk("cnt_4", 32'(shot_cnt), 4);
      force dut.shot_cnt_q = 16'hFFFF;
      #1 release dut.shot_cnt_q;
      press(); tick();
      shot_ready = 1'b1; tick(); shot_ready = 1'b0;
      chk("cnt_sat", 32'(shot_cnt), 32'hFFFF);
`endif

      // Reset mid-operation drops a pending shot, overrun, and debounce state.
      press(); tick();
      set_pos(12'd100, 12'd100);
      press(); tick();
      chk("mid_pend", 32'(shot_valid), 1);
      chk("mid_ovr", 32'(shot_ovr), 1);
      rst_n = 1'b0; tick();
      chk("mid_rst_valid", 32'(shot_valid), 0);
      chk("mid_rst_ovr", 32'(shot_ovr), 0);
      chk("mid_rst_left", 32'(left_out), 0);
      chk("mid_rst_x", 32'(xpos_out), 0);
      rst_n = 1'b1; tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
